// File: rtl/loader_pkg.sv
// Shared definitions for the UART firmware loader: command bytes, parser
// states and the bit-period computation.
package loader_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_GO    = 8'h47;
  localparam logic [7:0] CMD_HOLD  = 8'h48;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    BUS  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: two-flop synchronizer, mid-bit sampling with a down-counter,
// one-cycle rx_valid / rx_ferr pulses.
module uart_rx_core
  import loader_pkg::*;
#(
  parameter int unsigned clk_freq = 100000000,
  parameter int unsigned baud     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr
);

  localparam int unsigned DIV     = calc_div(clk_freq, baud);
  localparam logic [15:0] FULL_M1 = 16'(DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);

  rx_state_e   st_q, st_d;
  logic        sync1_q, sync2_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q    <= RX_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      sync1_q <= uart_rxd;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (st_q)
      RX_IDLE: if (!sync2_q) begin
        st_d  = RX_START;
        cnt_d = HALF_M1;
      end
      RX_START: if (cnt_q != '0) begin
        cnt_d = cnt_q - 16'd1;
      end else if (sync2_q) begin
        st_d = RX_IDLE;                  // line back high: glitch, not a start bit
      end else begin
        st_d  = RX_DATA;
        cnt_d = FULL_M1;
        bit_d = '0;
      end
      RX_DATA: if (cnt_q != '0) begin
        cnt_d = cnt_q - 16'd1;
      end else begin
        shreg_d = {sync2_q, shreg_q[7:1]};
        cnt_d   = FULL_M1;
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) st_d = RX_STOP;
      end
      RX_STOP: if (cnt_q != '0) begin
        cnt_d = cnt_q - 16'd1;
      end else begin
        st_d    = RX_IDLE;
        valid_d = sync2_q;
        ferr_d  = !sync2_q;
      end
      default: st_d = RX_IDLE;
    endcase
  end

  assign rx_valid = valid_q;
  assign rx_ferr  = ferr_q;
  assign rx_data  = shreg_q;

endmodule

// File: rtl/wb_uart_loader.sv
// UART-driven Wishbone write master: parses W/G/H command frames and issues
// single 32-bit writes; owns the CPU hold line.
//
// state | meaning
// IDLE  | waiting for a command byte
// ADDR  | collecting 4 address bytes, MSB first
// DATA  | collecting 4 data bytes, MSB first
// BUS   | Wishbone write in flight, waiting for ack or timeout
module wb_uart_loader
  import loader_pkg::*;
#(
  parameter int unsigned clk_freq    = 100000000,
  parameter int unsigned baud        = 115200,
  parameter bit          boot_hold   = 1'b1,
  parameter int unsigned ack_timeout = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rxd,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        cpu_hold_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned DIV     = calc_div(clk_freq, baud);
  localparam int unsigned TMO_CYC = 160 * DIV;
  localparam int          TW      = $clog2(TMO_CYC) + 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TMO_CYC - 1);
  localparam logic [15:0]   ACK_LOAD = 16'(ack_timeout - 1);

  logic       rx_valid, rx_ferr;
  logic [7:0] rx_data;

  uart_rx_core #(.clk_freq(clk_freq), .baud(baud)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .uart_rxd (uart_rxd),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ferr  (rx_ferr)
  );

  state_e        state_q, state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          hold_q, hold_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   ack_cnt_q, ack_cnt_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      hold_q     <= boot_hold;
      err_q      <= 1'b0;
      tmo_q      <= '0;
      ack_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      hold_q     <= hold_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      ack_cnt_q  <= ack_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    hold_d     = hold_q;
    err_d      = rx_ferr;
    tmo_d      = tmo_q;
    ack_cnt_d  = ack_cnt_q;
    case (state_q)
      IDLE: if (rx_valid) begin
        if (rx_data == CMD_WRITE) begin
          state_d    = ADDR;
          byte_cnt_d = '0;
          tmo_d      = TMO_LOAD;
        end else if (rx_data == CMD_GO) begin
          hold_d = 1'b0;
        end else if (rx_data == CMD_HOLD) begin
          hold_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      ADDR, DATA: if (rx_valid) begin
        // A byte arriving on the timeout's terminal cycle still counts.
        byte_cnt_d = byte_cnt_q + 2'd1;
        tmo_d      = TMO_LOAD;
        if (state_q == ADDR) addr_d = {addr_q[23:0], rx_data};
        else                 data_d = {data_q[23:0], rx_data};
        if (byte_cnt_q == 2'd3) begin
          state_d   = (state_q == ADDR) ? DATA : BUS;
          ack_cnt_d = ACK_LOAD;
        end
      end else if (tmo_q == '0) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q - TW'(1);
      end
      BUS: begin
        if (rx_valid) err_d = 1'b1;
        if (wb_ack_i) begin
          state_d = IDLE;
        end else if (ack_cnt_q == '0) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          ack_cnt_d = ack_cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_cyc_o   = (state_q == BUS);
  assign wb_stb_o   = wb_cyc_o;
  assign wb_we_o    = wb_cyc_o;
  assign wb_sel_o   = {4{wb_cyc_o}};
  assign wb_adr_o   = wb_cyc_o ? {addr_q[31:2], 2'b00} : 32'd0;
  assign wb_dat_o   = wb_cyc_o ? data_q : 32'd0;
  assign cpu_hold_o = hold_q;
  assign busy_o     = (state_q != IDLE);
  assign err_o      = err_q;

endmodule

// File: tb/tb_wb_uart_loader.sv
// Randomized self-checking bench for wb_uart_loader: serial frames in, the
// Wishbone writes, error pulses and CPU hold compared against a simple model.
module tb_wb_uart_loader;

  localparam int unsigned CLK_FREQ = 1600000;
  localparam int unsigned BAUD     = 100000;
  localparam int          DIV      = 16;
  localparam int          ACK_TO   = 255;
  localparam int          TMO      = 160 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        uart_rxd = 1'b1;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic        wb_ack_i = 1'b0;
  logic        cpu_hold_o, busy_o, err_o;

  wb_uart_loader #(
    .clk_freq(CLK_FREQ), .baud(BAUD), .boot_hold(1'b1), .ack_timeout(ACK_TO)
  ) dut (
    .clk(clk), .rst(rst), .uart_rxd(uart_rxd),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .cpu_hold_o(cpu_hold_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int ack_delay = 0;      // -1: never acknowledge
  int wait_cnt = 0, cyc_len = 0, last_cyc_len = 0;
  int err_seen = 0, exp_err = 0, bad_ctl = 0;
  logic exp_hold = 1'b1;
  logic [31:0] wr_adr_q[$];
  logic [31:0] wr_dat_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave model and bus monitor, working on the falling edge.
  always @(negedge clk) begin
    if (err_o) err_seen++;
    if (wb_cyc_o) begin
      wb_ack_i = (ack_delay >= 0) && (wait_cnt == ack_delay);
      wait_cnt++;
      cyc_len++;
      if (wb_sel_o !== 4'hF || wb_stb_o !== 1'b1 || wb_we_o !== 1'b1) bad_ctl++;
      if (wb_ack_i) begin
        wr_adr_q.push_back(wb_adr_o);
        wr_dat_q.push_back(wb_dat_o);
      end
    end else begin
      wb_ack_i = 1'b0;
      wait_cnt = 0;
      if (cyc_len != 0) last_cyc_len = cyc_len;
      cyc_len = 0;
      if (wb_sel_o !== 4'h0 || wb_stb_o !== 1'b0 || wb_we_o !== 1'b0) bad_ctl++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    if (stop_ok) begin
      uart_rxd = 1'b1;
      repeat (DIV) @(negedge clk);
    end else begin
      // Stop bit low only across its centre, then a quiet gap so the tail
      // cannot be taken for the next start bit.
      uart_rxd = 1'b0;
      repeat (DIV / 2 + 4) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (DIV / 2 - 4 + 2 * DIV) @(negedge clk);
    end
    uart_rxd = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8], 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8], 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy_o || wb_cyc_o) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk(tag, {31'd0, busy_o | wb_cyc_o}, 32'd0);
  endtask

  task automatic check_write(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_nwr"}, 32'(wr_adr_q.size()), 32'd1);
    if (wr_adr_q.size() > 0) begin
      chk({tag, "_adr"}, wr_adr_q.pop_front(), a & 32'hFFFF_FFFC);
      chk({tag, "_dat"}, wr_dat_q.pop_front(), d);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [7:0]  junk;
    int          r, n;

    repeat (5) @(negedge clk);
    chk("rst_cyc",  {31'd0, wb_cyc_o}, 32'd0);
    chk("rst_adr",  wb_adr_o, 32'd0);
    chk("rst_dat",  wb_dat_o, 32'd0);
    chk("rst_sel",  {28'd0, wb_sel_o}, 32'd0);
    chk("rst_hold", {31'd0, cpu_hold_o}, 32'd1);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_err",  {31'd0, err_o}, 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    send_byte(8'h47, 1'b1);
    exp_hold = 1'b0;
    chk("go_hold", {31'd0, cpu_hold_o}, {31'd0, exp_hold});
    send_byte(8'h48, 1'b1);
    exp_hold = 1'b1;
    chk("hold_hold", {31'd0, cpu_hold_o}, {31'd0, exp_hold});

    ack_delay = 2;
    send_frame(32'h0000_0107, 32'hDEAD_BEEF);
    wait_idle("dir_idle");
    check_write("dir", 32'h0000_0107, 32'hDEAD_BEEF);
    chk("dir_cyclen", last_cyc_len, 32'd3);
    chk("dir_err", err_seen, exp_err);

    for (int it = 0; it < 10; it++) begin
      r = $urandom_range(0, 5);
      if (r == 0) begin
        send_byte(8'h47, 1'b1);
        exp_hold = 1'b0;
      end else if (r == 1) begin
        send_byte(8'h48, 1'b1);
        exp_hold = 1'b1;
      end else if (r == 2) begin
        junk = 8'($urandom_range(0, 255));
        while (junk == 8'h57 || junk == 8'h47 || junk == 8'h48) junk = 8'($urandom_range(0, 255));
        send_byte(junk, 1'b1);
        exp_err++;
      end else begin
        a = $urandom;
        d = $urandom;
        ack_delay = $urandom_range(0, 4);
        send_frame(a, d);
        wait_idle("rnd_idle");
        check_write("rnd", a, d);
        chk("rnd_cyclen", last_cyc_len, ack_delay + 1);
      end
      wait_idle("rnd_end_idle");
      chk("rnd_hold", {31'd0, cpu_hold_o}, {31'd0, exp_hold});
      chk("rnd_err", err_seen, exp_err);
    end

    send_byte(8'h57, 1'b0);
    exp_err++;
    chk("ferr_busy", {31'd0, busy_o}, 32'd0);
    chk("ferr_err", err_seen, exp_err);
    chk("ferr_nwr", 32'(wr_adr_q.size()), 32'd0);
    ack_delay = 1;
    a = $urandom; d = $urandom;
    send_frame(a, d);
    wait_idle("ferr2_idle");
    check_write("ferr2", a, d);

    send_byte(8'h57, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    repeat (TMO - 200) @(negedge clk);
    chk("ibt_busy_pre", {31'd0, busy_o}, 32'd1);
    chk("ibt_err_pre", err_seen, exp_err);
    repeat (400) @(negedge clk);
    exp_err++;
    chk("ibt_busy", {31'd0, busy_o}, 32'd0);
    chk("ibt_err", err_seen, exp_err);
    a = $urandom; d = $urandom;
    ack_delay = 0;
    send_frame(a, d);
    wait_idle("ibt2_idle");
    check_write("ibt2", a, d);
    chk("ibt2_cyclen", last_cyc_len, 32'd1);

    ack_delay = -1;
    send_frame($urandom, $urandom);
    wait_idle("ato_idle");
    exp_err++;
    chk("ato_cyclen", last_cyc_len, ACK_TO);
    chk("ato_err", err_seen, exp_err);
    chk("ato_nwr", 32'(wr_adr_q.size()), 32'd0);

    send_frame($urandom, $urandom);
    n = 0;
    while (!wb_cyc_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rstbus_cyc_up", {31'd0, wb_cyc_o}, 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstbus_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rstbus_busy", {31'd0, busy_o}, 32'd0);
    chk("rstbus_hold", {31'd0, cpu_hold_o}, 32'd1);
    exp_hold = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstbus_nwr", 32'(wr_adr_q.size()), 32'd0);
    send_byte(8'h33, 1'b1);
    exp_err++;
    repeat (4) @(negedge clk);
    chk("bad_cmd_err", err_seen, exp_err);
    chk("bad_cmd_busy", {31'd0, busy_o}, 32'd0);

    chk("ctl_sigs", bad_ctl, 32'd0);
    chk("no_extra_wr", 32'(wr_adr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
